rca_limb_sequencer: RTL
=======================

// Module: rca_limb_sequencer
// PURPOSE
//   Upstream/downstream companion of the N-bit ripple-carry adder. Accepts W=N*LIMBS-bit
//   operands over a valid/ready handshake, feeds the external combinational RCA one N-bit
//   limb per cycle (LSB limb first), chains the carry through a register, and collects the
//   limb sums into a W-bit result presented on a second valid/ready handshake.
// PARAMETERS
//   N      4   limb width; equals the width of the attached RCA
//   LIMBS  4   limbs per operand (>=1); W = N*LIMBS
// PORTS
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   in_valid   in   1  operand request valid
//   in_ready   out  1  sequencer can accept a request
//   op_a       in   W  operand A
//   op_b       in   W  operand B
//   op_cin     in   1  carry into limb 0
//   add_a      out  N  current limb of A, to RCA a
//   add_b      out  N  current limb of B, to RCA b
//   add_cin    out  1  chained carry, to RCA carry-in
//   add_s      in   N  RCA sum, sampled same cycle
//   add_cout   in   1  RCA carry-out, sampled same cycle
//   out_valid  out  1  result valid
//   out_ready  in   1  consumer accepts result
//   res        out  W  W-bit sum
//   res_cout   out  1  carry out of top limb
// BEHAVIOUR
// - FSM states IDLE, RUN, DONE. Reset (async, rst_n=0): state IDLE, idx 0, carry 0,
//   res 0, res_cout 0, out_valid 0, add_a/add_b/add_cin 0, in_ready 1.
// - in_ready = (state==IDLE). Nothing is accepted in RUN or DONE.
// - IDLE: on in_valid&&in_ready, latch op_a, op_b; carry<=op_cin; idx<=0; go to RUN.
// - RUN: add_a = A[idx*N +: N], add_b = B[idx*N +: N], add_cin = carry (all registered
//   or derived from registers, glitch-free relative to clk). Each edge: res[idx*N +: N]<=add_s,
//   carry<=add_cout, idx<=idx+1. At idx==LIMBS-1: res_cout<=add_cout, go to DONE.
// - Latency: out_valid rises exactly LIMBS clock edges after the accepting edge.
// - DONE: out_valid=1; res/res_cout held stable until out_valid&&out_ready, then go to IDLE,
//   out_valid<=0. in_ready reasserts on the following cycle (no same-cycle accept).
// - add_a/add_b/add_cin are 0 in IDLE and DONE.
// - Arithmetic: {res_cout,res} == op_a + op_b + op_cin, modulo 2^(W+1); no saturation.
// - LIMBS==1: RUN lasts one cycle; out_valid one edge after accept.
// - Operand inputs are don't-care after the accepting edge; changes there have no effect.
// - Reset mid-RUN or mid-DONE: operation aborted, result discarded, all outputs to reset
//   values immediately (async); no partial out_valid after release.
// - idx width = max(1,$clog2(LIMBS)); idx never exceeds LIMBS-1.
// STRUCTURE
// - rca_pkg: state_t enum {IDLE,RUN,DONE}; default limb-width constant RCA_N=4.
// - One sub-module: rca_limb_shifter (W-bit operand register, loads on accept, shifts
//   right by N each RUN cycle, low N bits drive add_a/add_b); instanced twice.
// - Top: FSM, idx counter, carry register, result assembly.
// TESTING (N=4, LIMBS=4, W=16, bench models the RCA combinationally)
// - a=0x1234 b=0x4321 cin=0 -> res=0x5555 res_cout=0, out_valid 4 edges after accept.
// - a=0xFFFF b=0x0001 cin=0 -> res=0x0000 res_cout=1; add_cin=1 on limbs 1..3.
// - a=0xFFFF b=0x0000 cin=1 -> res=0x0000 res_cout=1; a=0x8000 b=0x8000 -> 0x0000, cout=1.
// - out_ready held 0 for 5 cycles in DONE -> out_valid=1, res stable, in_ready=0,
//   in_valid pulses ignored; on out_ready=1 -> IDLE, in_ready=1 next cycle.
// - rst_n pulsed low after 2 RUN edges -> out_valid=0, res=0, add_* = 0 at once; then
//   a=0x0F0F b=0x00F1 cin=0 -> res=0x1000 res_cout=0.
// - in_valid held 1, out_ready held 1, 3 random ops -> each result matches a+b+cin,
//   one accept per LIMBS+2 cycles, no accept while busy.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared types and constants for the limb-serial ripple-carry adder sequencer.
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int RCA_N = 4;

endpackage

// File: rtl/rca_limb_shifter.sv
// Operand register that loads a full-width operand and shifts it right one limb per step;
// the low limb feeds the external adder.
module rca_limb_shifter #(
    parameter int N     = 4,
    parameter int LIMBS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [N*LIMBS-1:0]   data_i,
    output logic [N-1:0]         limb_o
);

    localparam int W = N * LIMBS;

    logic [W-1:0] opnd_q;
    logic [W-1:0] opnd_d;

    // Next operand value: load wins over shift; a plain shift also covers the one-limb case.
    always_comb begin
        opnd_d = opnd_q;
        if (load_i) begin
            opnd_d = data_i;
        end else if (shift_i) begin
            opnd_d = opnd_q >> N;
        end else begin
            opnd_d = opnd_q;
        end
    end

    // Operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_q <= {W{1'b0}};
        end else begin
            opnd_q <= opnd_d;
        end
    end

    assign limb_o = opnd_q[N-1:0];

endmodule

// File: rtl/rca_limb_sequencer.sv
// Feeds a combinational N-bit RCA one limb per cycle (LSB first), chains the carry through a
// register and assembles the W-bit sum behind valid/ready handshakes on both sides.
module rca_limb_sequencer
    import rca_pkg::*;
#(
    parameter int N     = RCA_N,
    parameter int LIMBS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*LIMBS-1:0]   op_a,
    input  logic [N*LIMBS-1:0]   op_b,
    input  logic                 op_cin,
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    output logic                 add_cin,
    input  logic [N-1:0]         add_s,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*LIMBS-1:0]   res,
    output logic                 res_cout
);

    localparam int W    = N * LIMBS;
    localparam int IDXW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(LIMBS - 1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      res_q, res_d;
    logic              res_cout_q, res_cout_d;
    logic              load_s;
    logic              shift_s;
    logic [N-1:0]      a_limb_s;
    logic [N-1:0]      b_limb_s;

    rca_limb_shifter #(.N(N), .LIMBS(LIMBS)) u_shift_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_s),
        .shift_i (shift_s),
        .data_i  (op_a),
        .limb_o  (a_limb_s)
    );

    rca_limb_shifter #(.N(N), .LIMBS(LIMBS)) u_shift_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_s),
        .shift_i (shift_s),
        .data_i  (op_b),
        .limb_o  (b_limb_s)
    );

    // Next-state, limb counter, carry chain and result assembly.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        res_d      = res_q;
        res_cout_d = res_cout_q;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_s  = 1'b1;
                    carry_d = op_cin;
                    idx_d   = {IDXW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d[int'(idx_q)*N +: N] = add_s;
                carry_d = add_cout;
                shift_s = 1'b1;
                // The counter wraps to zero on the last limb so it never exceeds LIMBS-1.
                if (idx_q == IDX_LAST) begin
                    res_cout_d = add_cout;
                    idx_d      = {IDXW{1'b0}};
                    state_d    = DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = {IDXW{1'b0}};
            end
        endcase
    end

    // State, counter, carry and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= {IDXW{1'b0}};
            carry_q    <= 1'b0;
            res_q      <= {W{1'b0}};
            res_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            res_q      <= res_d;
            res_cout_q <= res_cout_d;
        end
    end

    // All outputs decode straight from registers, so they stay glitch-free and reset asynchronously.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign add_a     = (state_q == RUN) ? a_limb_s : {N{1'b0}};
    assign add_b     = (state_q == RUN) ? b_limb_s : {N{1'b0}};
    assign add_cin   = (state_q == RUN) ? carry_q  : 1'b0;
    assign res       = res_q;
    assign res_cout  = res_cout_q;

endmodule
